// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch counter: FSM states and end-of-range behaviour.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } stwc_state_e;

    typedef enum logic {
        WRAP,
        SATURATE
    } stwc_mode_e;

endpackage

// File: rtl/stwc_step.sv
// Combinational next-count and terminal-flag generator for one RUN step.
module stwc_step
    import stopwatch_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned MAX   = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             dir_i,
    input  stwc_mode_e       mode_i,
    output logic [WIDTH-1:0] count_o,
    output logic             terminal_o
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        count_o    = count_i;
        terminal_o = dir_i ? (count_i == '0) : (count_i == MAX_W);

        if (!terminal_o) begin
            count_o = dir_i ? (count_i - WIDTH'(1)) : (count_i + WIDTH'(1));
        end else if (mode_i == WRAP) begin
            count_o = dir_i ? MAX_W : '0;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Start/stop/clear elapsed-time counter with preload, wrap/saturate end behaviour
// and a lap-capture register; all outputs come straight from flops.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned MAX   = 2**WIDTH - 1
) (
    input  logic             clk_4_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dir_i,
    input  logic             mode_i,
    input  logic             lap_i,
    output logic [WIDTH-1:0] count_o,
    output logic             running_o,
    output logic             done_o,
    output logic             tc_o,
    output logic [WIDTH-1:0] lap_o,
    output logic             lap_valid_o
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    if ((MAX < 1) || (64'(MAX) > ((64'(1) << WIDTH) - 64'(1)))) begin : g_max_check
        $error("stopwatch_counter: MAX must lie in 1 .. 2**WIDTH-1");
    end

    stwc_state_e      state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] lap_q, lap_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             tc_q, tc_d;
    logic             lap_valid_q, lap_valid_d;

    logic [WIDTH-1:0] step_count;
    logic             step_terminal;

    stwc_step #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_step (
        .count_i    (count_q),
        .dir_i      (dir_i),
        .mode_i     (stwc_mode_e'(mode_i)),
        .count_o    (step_count),
        .terminal_o (step_terminal)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        lap_d       = lap_q;
        tc_d        = 1'b0;
        lap_valid_d = 1'b0;

        if (clear_i) begin
            state_d = IDLE;
            count_d = '0;
            lap_d   = '0;
        end else if (load_i) begin
            state_d = PAUSE;
            count_d = (load_val_i > MAX_W) ? MAX_W : load_val_i;
        end else begin
            // Lap uses the pre-edge count and does not disturb the step below.
            if (lap_i && ((state_q == RUN) || (state_q == PAUSE))) begin
                lap_d       = count_q;
                lap_valid_d = 1'b1;
            end

            if (stop_i) begin
                if (state_q == RUN) begin
                    state_d = PAUSE;
                end
            end else if (start_i && ((state_q == IDLE) || (state_q == PAUSE))) begin
                state_d = RUN;
            end else if (state_q == RUN) begin
                count_d = step_count;
                if (step_terminal) begin
                    tc_d = 1'b1;
                    if (stwc_mode_e'(mode_i) == SATURATE) begin
                        state_d = DONE;
                    end
                end
            end
        end

        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            count_q     <= '0;
            lap_q       <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            tc_q        <= 1'b0;
            lap_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values together.
            state_q     <= state_d;
            count_q     <= count_d;
            lap_q       <= lap_d;
            running_q   <= running_d;
            done_q      <= done_d;
            tc_q        <= tc_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign count_o     = count_q;
    assign lap_o       = lap_q;
    assign running_o   = running_q;
    assign done_o      = done_q;
    assign tc_o        = tc_q;
    assign lap_valid_o = lap_valid_q;

endmodule
